// File: rtl/branch_redirect.sv
// Control-transfer stage: resolves JAL/JALR/taken-branch targets, raises a handshaked
// redirect to fetch, flushes wrong-path instructions and flags misaligned targets.
module branch_redirect #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ex_valid_i,
    input  logic        is_branch_op_i,
    input  logic        is_jal_i,
    input  logic        is_jalr_i,
    input  logic        branch_taken_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_i,
    input  logic        fetch_ready_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        ex_stall_o,
    output logic [31:0] link_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        IDLE,
        REDIR,
        FLUSH
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        flush_q, flush_d;
    logic        ex_stall_q, ex_stall_d;
    logic        misalign_q, misalign_d;

    logic        ctl;
    logic        use_jalr;
    logic [31:0] tgt;
    logic        tgt_misaligned;

    // JAL outranks JALR when both decode flags are set; branches use the PC-relative path.
    assign ctl            = ex_valid_i & (is_jal_i | is_jalr_i | (is_branch_op_i & branch_taken_i));
    assign use_jalr       = is_jalr_i & ~is_jal_i;
    assign tgt            = use_jalr ? ((rs1_i + imm_i) & ~32'h1) : (pc_i + imm_i);
    assign tgt_misaligned = (tgt[1:0] != 2'b00);
    assign link_o         = pc_i + 32'd4;

    // NOTE: every always_comb variable gets a default first, so no path can infer a latch.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        ex_stall_d       = ex_stall_q;
        misalign_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ctl && tgt_misaligned) begin
                    misalign_d = 1'b1;
                end else if (ctl) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = tgt;
                    flush_d          = 1'b1;
                    ex_stall_d       = 1'b1;
                    state_d          = REDIR;
                end
            end
            REDIR: begin
                if (fetch_ready_i) begin
                    redirect_valid_d = 1'b0;
                    ex_stall_d       = 1'b0;
                    cnt_d            = CNT_LOAD;
                    state_d          = FLUSH;
                end
            end
            FLUSH: begin
                // cnt counts the remaining FLUSH cycles after this one.
                if (cnt_q == 4'd0) begin
                    flush_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d          = IDLE;
                redirect_valid_d = 1'b0;
                flush_d          = 1'b0;
                ex_stall_d       = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= IDLE;
            cnt_q            <= 4'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            flush_q          <= 1'b0;
            ex_stall_q       <= 1'b0;
            misalign_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            ex_stall_q       <= ex_stall_d;
            misalign_q       <= misalign_d;
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign flush_o          = flush_q;
    assign ex_stall_o       = ex_stall_q;
    assign misalign_o       = misalign_q;

endmodule

// File: tb/tb_branch_redirect.sv
// Directed bench for branch_redirect: hand-computed targets, handshake timing,
// flush length, misalignment pulses, wrap-around and reset abort.
module tb_branch_redirect;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        ex_valid_i;
    logic        is_branch_op_i;
    logic        is_jal_i;
    logic        is_jalr_i;
    logic        branch_taken_i;
    logic [31:0] pc_i;
    logic [31:0] imm_i;
    logic [31:0] rs1_i;
    logic        fetch_ready_i;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        ex_stall_o;
    logic [31:0] link_o;
    logic        misalign_o;

    int n_vec = 0;
    int n_err = 0;

    branch_redirect #(.FLUSH_CYCLES(2)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .ex_valid_i      (ex_valid_i),
        .is_branch_op_i  (is_branch_op_i),
        .is_jal_i        (is_jal_i),
        .is_jalr_i       (is_jalr_i),
        .branch_taken_i  (branch_taken_i),
        .pc_i            (pc_i),
        .imm_i           (imm_i),
        .rs1_i           (rs1_i),
        .fetch_ready_i   (fetch_ready_i),
        .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o   (redirect_pc_o),
        .flush_o         (flush_o),
        .ex_stall_o      (ex_stall_o),
        .link_o          (link_o),
        .misalign_o      (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_ops();
        ex_valid_i     = 1'b0;
        is_branch_op_i = 1'b0;
        is_jal_i       = 1'b0;
        is_jalr_i      = 1'b0;
        branch_taken_i = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic rv, input logic fl,
                              input logic st, input logic mis);
        check({tag, ".redirect_valid"}, 32'(redirect_valid_o), 32'(rv));
        check({tag, ".flush"},          32'(flush_o),          32'(fl));
        check({tag, ".ex_stall"},       32'(ex_stall_o),       32'(st));
        check({tag, ".misalign"},       32'(misalign_o),       32'(mis));
    endtask

    initial begin
        rst_n_i       = 1'b0;
        clear_ops();
        pc_i          = 32'h0;
        imm_i         = 32'h0;
        rs1_i         = 32'h0;
        fetch_ready_i = 1'b1;
        #3;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.redirect_pc", redirect_pc_o, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();

        // 1: taken branch, fetch ready immediately -> flush for 3 cycles.
        ex_valid_i = 1'b1; is_branch_op_i = 1'b1; branch_taken_i = 1'b1;
        pc_i = 32'h100; imm_i = 32'h20;
        tick();
        clear_ops();
        check_outs("t1.c1", 1'b1, 1'b1, 1'b1, 1'b0);
        check("t1.c1.redirect_pc", redirect_pc_o, 32'h120);
        tick();
        check_outs("t1.c2", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_outs("t1.c3", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_outs("t1.c4", 1'b0, 1'b0, 1'b0, 1'b0);

        // 2: not-taken branch, applied in the first IDLE cycle after FLUSH.
        ex_valid_i = 1'b1; is_branch_op_i = 1'b1; branch_taken_i = 1'b0;
        pc_i = 32'h100; imm_i = 32'h20;
        #1;
        check("t2.link", link_o, 32'h104);
        tick();
        clear_ops();
        check_outs("t2", 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: JALR clears bit 0 of rs1+imm.
        ex_valid_i = 1'b1; is_jalr_i = 1'b1;
        pc_i = 32'h200; rs1_i = 32'h1003; imm_i = 32'h1;
        #1;
        check("t3.link", link_o, 32'h204);
        tick();
        clear_ops();
        check_outs("t3", 1'b1, 1'b1, 1'b1, 1'b0);
        check("t3.redirect_pc", redirect_pc_o, 32'h1004);
        tick(); tick(); tick();
        check_outs("t3.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // 4: JAL with fetch stalled 3 cycles; toggled inputs must have no effect.
        fetch_ready_i = 1'b0;
        ex_valid_i = 1'b1; is_jal_i = 1'b1;
        pc_i = 32'h300; imm_i = 32'h40;
        tick();
        for (int c = 1; c <= 4; c++) begin
            ex_valid_i = c[0];
            is_jalr_i  = ~c[0];
            pc_i       = 32'h700 + 32'(c * 16);
            imm_i      = 32'h8 * 32'(c);
            rs1_i      = 32'h9000 + 32'(c * 4);
            check_outs($sformatf("t4.c%0d", c), 1'b1, 1'b1, 1'b1, 1'b0);
            check($sformatf("t4.c%0d.redirect_pc", c), redirect_pc_o, 32'h340);
            if (c == 4) fetch_ready_i = 1'b1;
            tick();
        end
        ex_valid_i = 1'b1; is_jal_i = 1'b1; is_jalr_i = 1'b0;
        check_outs("t4.c5", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_outs("t4.c6", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        clear_ops();
        check_outs("t4.c7", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("t4.c8", 1'b0, 1'b0, 1'b0, 1'b0);

        // 5: JAL to a misaligned target -> single-cycle misalign pulse.
        ex_valid_i = 1'b1; is_jal_i = 1'b1;
        pc_i = 32'h100; imm_i = 32'h6;
        tick();
        clear_ops();
        check_outs("t5", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("t5.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // JALR with bit 1 set after masking is still misaligned.
        ex_valid_i = 1'b1; is_jalr_i = 1'b1;
        rs1_i = 32'h1001; imm_i = 32'h1;
        tick();
        clear_ops();
        check_outs("t5b", 1'b0, 1'b0, 1'b0, 1'b1);

        // Priority: JAL beats JALR when both flags are set.
        ex_valid_i = 1'b1; is_jal_i = 1'b1; is_jalr_i = 1'b1;
        pc_i = 32'h500; imm_i = 32'h10; rs1_i = 32'h8000;
        tick();
        clear_ops();
        check("prio.redirect_pc", redirect_pc_o, 32'h510);
        check("prio.redirect_valid", 32'(redirect_valid_o), 32'h1);
        tick(); tick(); tick();

        // 6: wrap-around target; fetch held off so the redirect stays pending.
        fetch_ready_i = 1'b0;
        ex_valid_i = 1'b1; is_jal_i = 1'b1;
        pc_i = 32'hFFFF_FFF0; imm_i = 32'h20;
        tick();
        clear_ops();
        check("t6.redirect_pc", redirect_pc_o, 32'h10);
        check_outs("t6", 1'b1, 1'b1, 1'b1, 1'b0);

        // 7: reset while in REDIR clears everything immediately.
        #1;
        rst_n_i = 1'b0;
        #1;
        check_outs("t7.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("t7.rst.redirect_pc", redirect_pc_o, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        fetch_ready_i = 1'b1;
        tick();
        check_outs("t7.post", 1'b0, 1'b0, 1'b0, 1'b0);

        // Back in IDLE: a taken branch with a negative offset redirects normally.
        ex_valid_i = 1'b1; is_branch_op_i = 1'b1; branch_taken_i = 1'b1;
        pc_i = 32'h400; imm_i = 32'hFFFF_FFFC;
        tick();
        clear_ops();
        check_outs("t7.idle", 1'b1, 1'b1, 1'b1, 1'b0);
        check("t7.idle.redirect_pc", redirect_pc_o, 32'h3FC);
        tick(); tick(); tick();
        check_outs("t7.done", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
